ctrl_ajuste_campos: RTL and testbench
=====================================

CTRL_AJUSTE_CAMPOS -- requirements
Module: ctrl_ajuste_campos

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, sets the number of consecutive stable clocks needed to accept a new button level (10 ms at 100 MHz).
REQ-002 Parameter N_FIELDS, default 6, sets the number of editable fields, coded 1..N_FIELDS.
REQ-003 clk  in  1  system clock, 100 MHz.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 btn_prog  in  1  raw push-button that toggles program mode; asynchronous, bouncy.
REQ-006 btn_left  in  1  raw push-button that selects the previous field.
REQ-007 btn_right  in  1  raw push-button that selects the next field.
REQ-008 btn_up  in  1  raw push-button that increments the selected field.
REQ-009 btn_down  in  1  raw push-button that decrements the selected field.
REQ-010 en_count  out  4  selected field code: 0 none, 1 seg, 2 min, 3 hora, 4 dia, 5 mes, 6 año.
REQ-011 enUP  out  1  registered level, high while an increment is requested.
REQ-012 enDOWN  out  1  registered level, high while a decrement is requested.
REQ-013 prog_mode  out  1  registered level, high while in PROG state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each synchronized button SHALL have its own debounce counter and debounced register db_x.
REQ-016 Debounce rule: counter SHALL clear whenever synced == db_x; otherwise it SHALL increment, and on the clock where it equals DEBOUNCE_CYCLES-1 it SHALL load db_x <= synced and clear.
REQ-017 Any input pulse or glitch shorter than DEBOUNCE_CYCLES clocks SHALL produce no change in db_x.
REQ-018 A one-clock pulse p_x SHALL be generated on each 0->1 transition of db_prog, db_left and db_right; a release SHALL generate no pulse.
REQ-019 The FSM SHALL have two states: IDLE and PROG.
REQ-020 In IDLE, p_prog SHALL move the FSM to PROG with field = 1.
REQ-021 In IDLE, p_left, p_right, btn_up and btn_down SHALL be ignored.
REQ-022 In PROG, p_prog SHALL return the FSM to IDLE; field SHALL be cleared to 0.
REQ-023 In PROG, p_right SHALL set field to field+1, wrapping N_FIELDS -> 1.
REQ-024 In PROG, p_left SHALL set field to field-1, wrapping 1 -> N_FIELDS.
REQ-025 If p_left and p_right occur in the same clock, field SHALL be unchanged.
REQ-026 If p_prog coincides with p_left or p_right, p_prog SHALL take priority and the left/right pulse SHALL be discarded.
REQ-027 en_count SHALL equal field, registered; it SHALL be 0 in IDLE.
REQ-028 enUP SHALL be registered (db_up & ~db_down) in PROG, else 0.
REQ-029 enDOWN SHALL be registered (db_down & ~db_up) in PROG, else 0.
REQ-030 enUP and enDOWN SHALL never be high in the same clock.
REQ-031 Pressing up and down together SHALL drive both enUP and enDOWN low.
REQ-032 enUP and enDOWN SHALL be held for as long as the debounced button stays pressed; the downstream counter samples them at its own slow rate.
REQ-033 Latency from a raw edge held stable to the output change (enUP, enDOWN, en_count, prog_mode) SHALL be exactly DEBOUNCE_CYCLES+3 rising edges of clk.
REQ-034 On leaving PROG, enUP and enDOWN SHALL drop on the same clock that en_count becomes 0.

Reset
REQ-035 While reset is high, the FSM SHALL be IDLE and field SHALL be 0.
REQ-036 While reset is high, all synchronizers, debounce counters, db_x and pulse registers SHALL be 0.
REQ-037 While reset is high, en_count SHALL be 0 and enUP, enDOWN, prog_mode SHALL all be 0.
REQ-038 Reset asserted mid-debounce or in PROG SHALL abort the operation immediately with no residual pulse after release.
REQ-039 A button still held at reset release SHALL be seen as a new press after DEBOUNCE_CYCLES+3 clocks.

Verification (DEBOUNCE_CYCLES=4)
REQ-040 Hold btn_prog 10 clocks -> prog_mode=1 and en_count=1 exactly 7 edges after the raw rise.
REQ-041 In PROG field 1, apply 3-clock btn_right glitches -> en_count stays 1; then a clean btn_right press -> en_count=2.
REQ-042 Apply 6 clean btn_right presses from field 5 -> sequence 6,1,2,3,4,5; from field 1, one btn_left -> 6.
REQ-043 At en_count=5, hold btn_up 20 clocks -> enUP=1 for the hold plus latency and enDOWN=0; then hold up and down together -> both 0.
REQ-044 Press btn_prog and btn_left simultaneously in PROG -> IDLE, en_count=0, field left unmodified by the left press.
REQ-045 Assert reset while in PROG with btn_up held -> all outputs 0 at once; after release with btn_up still held -> enUP stays 0 (IDLE).

Source files
------------

// File: rtl/ctrl_ajuste_campos.sv
// Field-selection controller for the clock/calendar adjust panel: debounces five buttons
// and walks the editable fields while in program mode.
module ctrl_ajuste_campos #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int N_FIELDS        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       prog_mode
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     FLD_MAX = 4'(N_FIELDS);

  // Bit order: 0 prog, 1 left, 2 right, 3 up, 4 down
  logic [4:0]    btn_raw;
  logic [4:0]    sync1, sync2;
  logic [4:0]    db, db_q;
  logic [4:0]    pulse;
  logic [CW-1:0] cnt [5];

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left, btn_prog};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive clocks of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) db_q <= '0;
    else       db_q <= db;
  end

  assign pulse = db & ~db_q;

  typedef enum logic {IDLE, PROG} state_t;

  state_t     state, state_nx;
  logic [3:0] field, field_nx;
  logic       up_nx, dn_nx;

  always_comb begin
    state_nx = state;
    field_nx = field;
    case (state)
      IDLE: begin
        if (pulse[0]) begin
          state_nx = PROG;
          field_nx = 4'd1;
        end
      end
      PROG: begin
        if (pulse[0]) begin
          state_nx = IDLE;
          field_nx = 4'd0;
        end else if (pulse[1] && !pulse[2]) begin
          field_nx = (field <= 4'd1) ? FLD_MAX : field - 4'd1;
        end else if (pulse[2] && !pulse[1]) begin
          field_nx = (field >= FLD_MAX) ? 4'd1 : field + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        field_nx = 4'd0;
      end
    endcase
    // Qualified by the next state so the enables drop together with en_count on exit
    up_nx = (state_nx == PROG) && db[3] && !db[4];
    dn_nx = (state_nx == PROG) && db[4] && !db[3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      field  <= 4'd0;
      enUP   <= 1'b0;
      enDOWN <= 1'b0;
    end else begin
      state  <= state_nx;
      field  <= field_nx;
      enUP   <= up_nx;
      enDOWN <= dn_nx;
    end
  end

  assign en_count  = field;
  assign prog_mode = (state == PROG);

endmodule

// File: tb/tb_ctrl_ajuste_campos.sv
// Bench for ctrl_ajuste_campos: directed scenarios plus random button activity,
// checked every clock against a cycle-level reference model.
module tb_ctrl_ajuste_campos;

  localparam int DC = 4;
  localparam int NF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_prog, btn_left, btn_right, btn_up, btn_down;
  logic [3:0] en_count;
  logic       enUP, enDOWN, prog_mode;

  int errors = 0;
  int checks = 0;

  ctrl_ajuste_campos #(.DEBOUNCE_CYCLES(DC), .N_FIELDS(NF)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_prog  (btn_prog),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .en_count  (en_count),
    .enUP      (enUP),
    .enDOWN    (enDOWN),
    .prog_mode (prog_mode)
  );

  always #5 clk = ~clk;

  // Reference model: a button is "seen" two clocks after it is sampled; it becomes
  // accepted after DC consecutive seen values that differ from the accepted one.
  logic [4:0] raw_hist [$];
  int         run [5];
  logic [4:0] mdb, mdb_prev;
  bit         mprog;
  int         mfield;
  bit         mup, mdn;

  function automatic logic [4:0] raw_now();
    return {btn_down, btn_up, btn_right, btn_left, btn_prog};
  endfunction

  task automatic model_clear();
    raw_hist.delete();
    for (int i = 0; i < 5; i++) run[i] = 0;
    mdb = '0; mdb_prev = '0;
    mprog = 0; mfield = 0; mup = 0; mdn = 0;
  endtask

  task automatic model_step();
    logic [4:0] rise, seen;
    bit nprog;
    int nfield;
    if (reset) begin
      model_clear();
      return;
    end
    rise   = mdb & ~mdb_prev;
    nprog  = mprog;
    nfield = mfield;
    if (rise[0]) begin
      nprog  = !mprog;
      nfield = nprog ? 1 : 0;
    end else if (mprog && rise[1] && !rise[2]) begin
      nfield = (mfield == 1) ? NF : mfield - 1;
    end else if (mprog && rise[2] && !rise[1]) begin
      nfield = (mfield % NF) + 1;
    end
    mup    = nprog && mdb[3] && !mdb[4];
    mdn    = nprog && mdb[4] && !mdb[3];
    mprog  = nprog;
    mfield = nfield;

    mdb_prev = mdb;
    seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'b0;
    raw_hist.push_back(raw_now());
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    for (int i = 0; i < 5; i++) begin
      if (seen[i] == mdb[i]) run[i] = 0;
      else begin
        run[i]++;
        if (run[i] == DC) begin
          mdb[i] = seen[i];
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("en_count", int'(en_count), mfield);
    check("prog_mode", int'(prog_mode), int'(mprog));
    check("enUP", int'(enUP), int'(mup));
    check("enDOWN", int'(enDOWN), int'(mdn));
    check("up_dn_exclusive", int'(enUP & enDOWN), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_prog  = v;
      1: btn_left  = v;
      2: btn_right = v;
      3: btn_up    = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    ticks(DC + 4);
    set_btn(idx, 1'b0);
    ticks(DC + 4);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_en_count", int'(en_count), 0);
    check("rst_prog_mode", int'(prog_mode), 0);
    check("rst_enUP", int'(enUP), 0);
    check("rst_enDOWN", int'(enDOWN), 0);
    ticks(n);
    reset = 1'b0;
  endtask

  int seq_exp [6] = '{6, 1, 2, 3, 4, 5};

  initial begin
    reset = 1'b0;
    {btn_prog, btn_left, btn_right, btn_up, btn_down} = '0;
    @(posedge clk); #1;
    do_reset(3);

    // Program entry latency: change at the 7th edge, not before
    btn_prog = 1'b1;
    for (int i = 1; i <= DC + 2; i++) begin
      tick();
      check("prog_early", int'(prog_mode), 0);
    end
    tick();
    check("prog_lat_mode", int'(prog_mode), 1);
    check("prog_lat_field", int'(en_count), 1);
    ticks(3);
    btn_prog = 1'b0;
    ticks(DC + 6);

    // Short glitches on right are filtered
    for (int g = 0; g < 3; g++) begin
      btn_right = 1'b1; ticks(DC - 1);
      btn_right = 1'b0; ticks(DC + 2);
    end
    check("glitch_field", int'(en_count), 1);
    press(2);
    check("right_clean", int'(en_count), 2);

    // Walk to 5, then six rights wrap through N_FIELDS
    for (int i = 0; i < 3; i++) press(2);
    check("field5", int'(en_count), 5);
    for (int i = 0; i < 6; i++) begin
      press(2);
      check("right_seq", int'(en_count), seq_exp[i]);
    end
    press(2); press(2);
    check("field1", int'(en_count), 1);
    press(1);
    check("left_wrap", int'(en_count), 6);
    press(1);
    check("left_to5", int'(en_count), 5);

    // Up held, then up+down together
    btn_up = 1'b1;
    ticks(DC + 3);
    check("up_on", int'(enUP), 1);
    check("up_no_down", int'(enDOWN), 0);
    ticks(20 - (DC + 3));
    btn_down = 1'b1;
    ticks(DC + 3);
    check("both_up", int'(enUP), 0);
    check("both_down", int'(enDOWN), 0);
    btn_up = 1'b0; btn_down = 1'b0;
    ticks(DC + 4);

    // Prog and left together: exit wins
    btn_prog = 1'b1; btn_left = 1'b1;
    ticks(DC + 3);
    check("exit_mode", int'(prog_mode), 0);
    check("exit_field", int'(en_count), 0);
    btn_prog = 1'b0; btn_left = 1'b0;
    ticks(DC + 4);

    // Reset in PROG with up held
    press(0);
    check("reenter", int'(en_count), 1);
    btn_up = 1'b1;
    ticks(DC + 5);
    check("up_before_rst", int'(enUP), 1);
    do_reset(2);
    ticks(3 * DC);
    check("up_after_rst", int'(enUP), 0);
    check("mode_after_rst", int'(prog_mode), 0);
    btn_up = 1'b0;
    ticks(DC + 4);

    // Random activity against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) set_btn(b, ~raw_now()[b]);
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
